// File: rtl/ahb_apb_pkg.sv
// Shared AHB/APB encodings, bridge FSM state type and byte-lane helpers.
package ahb_apb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE  = 3'd0;
  localparam logic [2:0] HSIZE_HALF  = 3'd1;
  localparam logic [2:0] HSIZE_WORD  = 3'd2;
  localparam logic [2:0] HSIZE_DWORD = 3'd3;

  // Width of the decoded slave-index field; wide enough for 16 slaves so that
  // addresses beyond the populated slaves are caught rather than aliased.
  localparam int unsigned SLV_FIELD_W = 4;

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StAccess,
    StDone,
    StErr1,
    StErr2
  } bridge_state_t;

  function automatic logic [7:0] byte_strobe(input logic [2:0] addr_lo, input logic [2:0] size,
                                             input logic bus64);
    logic [7:0] base;
    logic [2:0] ofs;
    case (size)
      HSIZE_BYTE: base = 8'h01;
      HSIZE_HALF: base = 8'h03;
      HSIZE_WORD: base = 8'h0F;
      default:    base = 8'hFF;
    endcase
    ofs = bus64 ? addr_lo : {1'b0, addr_lo[1:0]};
    return base << ofs;
  endfunction

  function automatic logic misaligned(input logic [2:0] addr_lo, input logic [2:0] size);
    logic res;
    case (size)
      HSIZE_BYTE: res = 1'b0;
      HSIZE_HALF: res = addr_lo[0];
      HSIZE_WORD: res = |addr_lo[1:0];
      default:    res = |addr_lo;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/apb_slave_mux.sv
// Slave-index decode to one-hot select, and return-path mux from the addressed slave.
module apb_slave_mux
  import ahb_apb_pkg::*;
#(
  parameter int unsigned NUM_SLAVES = 4,
  parameter int unsigned DATA_W     = 32
) (
  input  logic [SLV_FIELD_W-1:0]       idx,
  input  logic                         en,
  output logic [NUM_SLAVES-1:0]        psel,
  input  logic [NUM_SLAVES-1:0]        pready,
  input  logic [NUM_SLAVES-1:0]        pslverr,
  input  logic [NUM_SLAVES*DATA_W-1:0] prdata,
  output logic                         sel_ready,
  output logic                         sel_slverr,
  output logic [DATA_W-1:0]            sel_rdata
);

  always_comb begin
    psel       = '0;
    sel_ready  = 1'b0;
    sel_slverr = 1'b0;
    sel_rdata  = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (idx == SLV_FIELD_W'(i)) begin
        psel[i]    = en;
        sel_ready  = pready[i];
        sel_slverr = pslverr[i];
        sel_rdata  = prdata[i*DATA_W +: DATA_W];
      end
    end
  end

endmodule

// File: rtl/ahb2apb_bridge_mc.sv
// Multi-slave AHB-Lite to APB bridge with byte strobes, slave-error and Pready-timeout
// reporting as a two-cycle AHB ERROR response.
module ahb2apb_bridge_mc
  import ahb_apb_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned NUM_SLAVES = 4,
  parameter int unsigned SLV_LSB    = 12,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic                         Hclk,
  input  logic                         Hresetn,
  input  logic                         Hsel,
  input  logic [1:0]                   Htrans,
  input  logic [ADDR_W-1:0]            Haddr,
  input  logic                         Hwrite,
  input  logic [2:0]                   Hsize,
  input  logic [DATA_W-1:0]            Hwdata,
  input  logic                         Hready,
  output logic                         Hreadyout,
  output logic                         Hresp,
  output logic [DATA_W-1:0]            Hrdata,
  output logic [NUM_SLAVES-1:0]        Psel,
  output logic                         Penable,
  output logic                         Pwrite,
  output logic [ADDR_W-1:0]            Paddr,
  output logic [DATA_W-1:0]            Pwdata,
  output logic [DATA_W/8-1:0]          Pstrb,
  input  logic [NUM_SLAVES-1:0]        Pready,
  input  logic [NUM_SLAVES-1:0]        Pslverr,
  input  logic [NUM_SLAVES*DATA_W-1:0] Prdata
);

  localparam int unsigned STRB_W    = DATA_W / 8;
  localparam logic [2:0]  SIZE_MAX  = (DATA_W == 64) ? HSIZE_DWORD : HSIZE_WORD;
  localparam int unsigned CNT_W     = $clog2(TIMEOUT + 2);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT);

  bridge_state_t          state_q;
  logic [SLV_FIELD_W-1:0] idx_q;
  logic [SLV_FIELD_W-1:0] req_idx;
  logic                   psel_en_q;
  logic [CNT_W-1:0]       cnt_q;
  logic                   valid;
  logic                   bad_req;
  logic                   sel_ready;
  logic                   sel_slverr;
  logic [DATA_W-1:0]      sel_rdata;

  assign valid   = Hsel & Hready & ((Htrans == HTRANS_NONSEQ) | (Htrans == HTRANS_SEQ));
  assign req_idx = Haddr[SLV_LSB +: SLV_FIELD_W];
  assign bad_req = (32'(req_idx) >= NUM_SLAVES) | (Hsize > SIZE_MAX) |
                   misaligned(Haddr[2:0], Hsize);

  apb_slave_mux #(
    .NUM_SLAVES(NUM_SLAVES),
    .DATA_W    (DATA_W)
  ) u_slave_mux (
    .idx       (idx_q),
    .en        (psel_en_q),
    .psel      (Psel),
    .pready    (Pready),
    .pslverr   (Pslverr),
    .prdata    (Prdata),
    .sel_ready (sel_ready),
    .sel_slverr(sel_slverr),
    .sel_rdata (sel_rdata)
  );

  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) begin
      state_q   <= StIdle;
      idx_q     <= '0;
      psel_en_q <= 1'b0;
      cnt_q     <= '0;
      Hreadyout <= 1'b1;
      Hresp     <= 1'b0;
      Hrdata    <= '0;
      Penable   <= 1'b0;
      Pwrite    <= 1'b0;
      Paddr     <= '0;
      Pwdata    <= '0;
      Pstrb     <= '0;
    end else begin
      unique case (state_q)
        StIdle, StDone, StErr2: begin
          state_q   <= StIdle;
          Hreadyout <= 1'b1;
          Hresp     <= 1'b0;
          if (valid) begin
            Hreadyout <= 1'b0;
            if (bad_req) begin
              // Rejected before any APB activity; APB outputs keep their old values.
              state_q <= StErr1;
              Hresp   <= 1'b1;
            end else begin
              state_q   <= StSetup;
              idx_q     <= req_idx;
              psel_en_q <= 1'b1;
              cnt_q     <= '0;
              Paddr     <= Haddr;
              Pwrite    <= Hwrite;
              Pstrb     <= Hwrite ? STRB_W'(byte_strobe(Haddr[2:0], Hsize, DATA_W == 64)) : '0;
            end
          end
        end
        StSetup: begin
          state_q <= StAccess;
          Penable <= 1'b1;
          cnt_q   <= cnt_q + 1'b1;
          if (Pwrite) Pwdata <= Hwdata;
        end
        StAccess: begin
          if (sel_ready) begin
            psel_en_q <= 1'b0;
            Penable   <= 1'b0;
            if (!Pwrite) Hrdata <= sel_rdata;
            if (sel_slverr) begin
              state_q <= StErr1;
              Hresp   <= 1'b1;
            end else begin
              state_q   <= StDone;
              Hreadyout <= 1'b1;
            end
          end else if ((TIMEOUT != 0) && (cnt_q == CNT_LIMIT)) begin
            // cnt_q counts ACCESS cycles including the current one.
            psel_en_q <= 1'b0;
            Penable   <= 1'b0;
            state_q   <= StErr1;
            Hresp     <= 1'b1;
          end else if (cnt_q != {CNT_W{1'b1}}) begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StErr1: begin
          state_q   <= StErr2;
          Hreadyout <= 1'b1;
          Hresp     <= 1'b1;
        end
        default: begin
          state_q   <= StIdle;
          Hreadyout <= 1'b1;
          Hresp     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ahb2apb_bridge_mc.sv
// Scoreboard bench for ahb2apb_bridge_mc: APB and AHB expectations are queued with the
// stimulus and popped by negedge monitors when the bridge completes each phase.
module tb_ahb2apb_bridge_mc;

  localparam int unsigned NS = 4;
  localparam int unsigned DW = 32;
  localparam int unsigned AW = 32;

  logic           Hclk = 1'b0;
  logic           Hresetn;
  logic           Hsel;
  logic [1:0]     Htrans;
  logic [AW-1:0]  Haddr;
  logic           Hwrite;
  logic [2:0]     Hsize;
  logic [DW-1:0]  Hwdata;
  wire            hready_w;
  logic           Hreadyout;
  logic           Hresp;
  logic [DW-1:0]  Hrdata;
  logic [NS-1:0]  Psel;
  logic           Penable;
  logic           Pwrite;
  logic [AW-1:0]  Paddr;
  logic [DW-1:0]  Pwdata;
  logic [DW/8-1:0] Pstrb;
  logic [NS-1:0]  Pready;
  logic [NS-1:0]  Pslverr;
  logic [NS*DW-1:0] Prdata;

  // Single AHB slave on the bus, so the bus-wide ready is the bridge's own.
  assign hready_w = Hreadyout;

  ahb2apb_bridge_mc #(
    .ADDR_W    (AW),
    .DATA_W    (DW),
    .NUM_SLAVES(NS),
    .SLV_LSB   (12),
    .TIMEOUT   (8)
  ) dut (
    .Hclk     (Hclk),
    .Hresetn  (Hresetn),
    .Hsel     (Hsel),
    .Htrans   (Htrans),
    .Haddr    (Haddr),
    .Hwrite   (Hwrite),
    .Hsize    (Hsize),
    .Hwdata   (Hwdata),
    .Hready   (hready_w),
    .Hreadyout(Hreadyout),
    .Hresp    (Hresp),
    .Hrdata   (Hrdata),
    .Psel     (Psel),
    .Penable  (Penable),
    .Pwrite   (Pwrite),
    .Paddr    (Paddr),
    .Pwdata   (Pwdata),
    .Pstrb    (Pstrb),
    .Pready   (Pready),
    .Pslverr  (Pslverr),
    .Prdata   (Prdata)
  );

  always #5 Hclk = ~Hclk;

  typedef struct {
    int          id;
    logic [3:0]  psel;
    logic [31:0] paddr;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    int          pen;
  } apb_exp_t;

  typedef struct {
    int          id;
    logic        err;
    logic        rd;
    logic [31:0] rdata;
  } ahb_exp_t;

  apb_exp_t apb_q[$];
  ahb_exp_t ahb_q[$];

  int n_chk = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic exp_apb(input int id, input logic [3:0] psel, input logic [31:0] paddr,
                         input logic pwrite, input logic [31:0] pwdata, input logic [3:0] pstrb,
                         input int pen);
    apb_exp_t e;
    e.id = id; e.psel = psel; e.paddr = paddr; e.pwrite = pwrite;
    e.pwdata = pwdata; e.pstrb = pstrb; e.pen = pen;
    apb_q.push_back(e);
  endtask

  task automatic exp_ahb(input int id, input logic err, input logic rd, input logic [31:0] rdata);
    ahb_exp_t e;
    e.id = id; e.err = err; e.rd = rd; e.rdata = rdata;
    ahb_q.push_back(e);
  endtask

  // APB slave model: selected slave waits wait_n ACCESS cycles; unselected slaves drive
  // the opposite handshake so any leakage from them is visible.
  int   wait_n = 0;
  int   acc_n = 0;
  logic slverr_mode = 1'b0;
  logic ready_now;

  always @(negedge Hclk) begin
    if (Penable) acc_n++;
    else acc_n = 0;
    ready_now = Penable && (acc_n > wait_n);
    Pready  = ready_now ? Psel : ~Psel;
    Pslverr = slverr_mode ? (ready_now ? Psel : '0) : ~Psel;
  end

  // Monitors
  logic     mon_en = 1'b0;
  logic     pen_prev = 1'b0;
  logic     rdy_prev = 1'b1;
  logic     hresp_prev = 1'b0;
  int       cyc = 0;
  int       done_cyc = 0;
  int       setup_gap = 0;
  int       pen_cnt = 0;
  logic [3:0]  cap_psel;
  logic [31:0] cap_paddr;
  logic        cap_pwrite;
  logic [31:0] cap_pwdata;
  logic [3:0]  cap_pstrb;
  apb_exp_t ae;
  ahb_exp_t he;

  always @(negedge Hclk) begin
    cyc++;
    if (mon_en) begin
      if (Psel != 0 && !Penable) setup_gap = cyc - done_cyc;
      if (Penable) begin
        if (!pen_prev) begin
          cap_psel = Psel; cap_paddr = Paddr; cap_pwrite = Pwrite;
          cap_pwdata = Pwdata; cap_pstrb = Pstrb; pen_cnt = 1;
        end else begin
          pen_cnt++;
        end
      end
      if (pen_prev && !Penable) begin
        if (apb_q.size() == 0) begin
          check_eq("apb_unexpected", 1, 0);
        end else begin
          ae = apb_q.pop_front();
          check_eq($sformatf("apb%0d_psel", ae.id), cap_psel, ae.psel);
          check_eq($sformatf("apb%0d_paddr", ae.id), cap_paddr, ae.paddr);
          check_eq($sformatf("apb%0d_pwrite", ae.id), cap_pwrite, ae.pwrite);
          check_eq($sformatf("apb%0d_pstrb", ae.id), cap_pstrb, ae.pstrb);
          check_eq($sformatf("apb%0d_penable_cycles", ae.id), pen_cnt, ae.pen);
          if (ae.pwrite) check_eq($sformatf("apb%0d_pwdata", ae.id), cap_pwdata, ae.pwdata);
          check_eq($sformatf("apb%0d_psel_drop", ae.id), Psel, 0);
        end
      end
      if (Hreadyout && !rdy_prev) begin
        done_cyc = cyc;
        if (ahb_q.size() == 0) begin
          check_eq("ahb_unexpected", 1, 0);
        end else begin
          he = ahb_q.pop_front();
          check_eq($sformatf("ahb%0d_hresp", he.id), Hresp, he.err);
          if (he.err) check_eq($sformatf("ahb%0d_err1_hresp", he.id), hresp_prev, 1);
          if (he.rd) check_eq($sformatf("ahb%0d_hrdata", he.id), Hrdata, he.rdata);
        end
      end
    end
    pen_prev   = Penable;
    rdy_prev   = Hreadyout;
    hresp_prev = Hresp;
  end

  // Drive an address phase, wait for it to be accepted, then present its write data.
  task automatic issue(input logic [31:0] addr, input logic wr, input logic [2:0] size,
                       input logic [31:0] wdata);
    logic ok;
    int   n = 0;
    Hsel = 1'b1; Htrans = 2'b10; Haddr = addr; Hwrite = wr; Hsize = size;
    do begin
      ok = Hreadyout;
      @(posedge Hclk); #1;
      n++;
    end while (!ok && n < 100);
    if (!ok) check_eq("addr_accept_timeout", 0, 1);
    Hwdata = wdata; Hsel = 1'b0; Htrans = 2'b00;
  endtask

  task automatic drain();
    int n = 0;
    while (!Hreadyout && n < 100) begin
      @(posedge Hclk); #1;
      n++;
    end
    if (!Hreadyout) check_eq("drain_timeout", 0, 1);
    repeat (3) @(posedge Hclk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1, "watchdog");
  end

  initial begin
    Hresetn = 1'b0; Hsel = 1'b0; Htrans = 2'b00; Haddr = '0; Hwrite = 1'b0;
    Hsize = 3'd0; Hwdata = '0; Pready = '0; Pslverr = '0;
    Prdata = {32'h3333_3333, 32'h1234_5678, 32'h1111_1111, 32'h0BAD_F00D};

    #12;
    check_eq("rst_hreadyout", Hreadyout, 1);
    check_eq("rst_hresp", Hresp, 0);
    check_eq("rst_psel", Psel, 0);
    check_eq("rst_penable", Penable, 0);
    check_eq("rst_paddr", Paddr, 0);
    check_eq("rst_pstrb", Pstrb, 0);
    check_eq("rst_hrdata", Hrdata, 0);
    @(negedge Hclk);
    Hresetn = 1'b1;
    mon_en = 1'b1;
    @(posedge Hclk); #1;

    // Word write to slave 1 with explicit latency checks
    exp_apb(1, 4'b0010, 32'h0000_1004, 1'b1, 32'hDEAD_BEEF, 4'hF, 1);
    exp_ahb(1, 1'b0, 1'b0, '0);
    issue(32'h0000_1004, 1'b1, 3'd2, 32'hDEAD_BEEF);
    check_eq("t1_psel", Psel, 4'b0010);
    check_eq("t1_penable", Penable, 0);
    @(posedge Hclk); #1;
    check_eq("t2_penable", Penable, 1);
    check_eq("t2_hreadyout", Hreadyout, 0);
    @(posedge Hclk); #1;
    check_eq("t3_hreadyout", Hreadyout, 1);
    drain();

    // Read slave 2 with three wait states
    wait_n = 3;
    exp_apb(2, 4'b0100, 32'h0000_2010, 1'b0, '0, 4'h0, 4);
    exp_ahb(2, 1'b0, 1'b1, 32'h1234_5678);
    issue(32'h0000_2010, 1'b0, 3'd2, '0);
    drain();
    wait_n = 0;

    // Sub-word strobes
    exp_apb(3, 4'b0001, 32'h0000_0003, 1'b1, 32'hAA00_0000, 4'b1000, 1);
    exp_ahb(3, 1'b0, 1'b0, '0);
    issue(32'h0000_0003, 1'b1, 3'd0, 32'hAA00_0000);
    drain();
    exp_apb(4, 4'b0100, 32'h0000_2006, 1'b1, 32'h5566_0000, 4'b1100, 1);
    exp_ahb(4, 1'b0, 1'b0, '0);
    issue(32'h0000_2006, 1'b1, 3'd1, 32'h5566_0000);
    drain();

    // Unpopulated slave: no APB cycle, two-cycle ERROR
    exp_ahb(5, 1'b1, 1'b0, '0);
    issue(32'h0000_5000, 1'b1, 3'd2, 32'h0);
    check_eq("bad_addr_psel", Psel, 0);
    check_eq("bad_addr_err1_ready", Hreadyout, 0);
    check_eq("bad_addr_err1_resp", Hresp, 1);
    @(posedge Hclk); #1;
    check_eq("bad_addr_err2_ready", Hreadyout, 1);
    check_eq("bad_addr_err2_resp", Hresp, 1);
    @(posedge Hclk); #1;
    check_eq("bad_addr_after_resp", Hresp, 0);
    drain();

    // Misaligned word and oversize transfer
    exp_ahb(6, 1'b1, 1'b0, '0);
    issue(32'h0000_1002, 1'b0, 3'd2, '0);
    drain();
    exp_ahb(7, 1'b1, 1'b0, '0);
    issue(32'h0000_1000, 1'b0, 3'd3, '0);
    drain();

    // Pready stuck low: dropped after 8 ACCESS cycles, next transfer proceeds
    wait_n = 1000;
    exp_apb(8, 4'b1000, 32'h0000_3000, 1'b0, '0, 4'h0, 8);
    exp_ahb(8, 1'b1, 1'b0, '0);
    issue(32'h0000_3000, 1'b0, 3'd2, '0);
    drain();
    wait_n = 0;
    exp_apb(9, 4'b1000, 32'h0000_3008, 1'b1, 32'hCAFE_F00D, 4'hF, 1);
    exp_ahb(9, 1'b0, 1'b0, '0);
    issue(32'h0000_3008, 1'b1, 3'd2, 32'hCAFE_F00D);
    drain();

    // Slave error on a read still returns the slave's data
    slverr_mode = 1'b1;
    exp_apb(10, 4'b0010, 32'h0000_1008, 1'b0, '0, 4'h0, 1);
    exp_ahb(10, 1'b1, 1'b1, 32'h1111_1111);
    issue(32'h0000_1008, 1'b0, 3'd2, '0);
    drain();
    slverr_mode = 1'b0;

    // Back-to-back write then read with no IDLE gap
    exp_apb(11, 4'b0001, 32'h0000_0010, 1'b1, 32'h0102_0304, 4'hF, 1);
    exp_ahb(11, 1'b0, 1'b0, '0);
    exp_apb(12, 4'b0100, 32'h0000_2000, 1'b0, '0, 4'h0, 1);
    exp_ahb(12, 1'b0, 1'b1, 32'h1234_5678);
    issue(32'h0000_0010, 1'b1, 3'd2, 32'h0102_0304);
    issue(32'h0000_2000, 1'b0, 3'd2, '0);
    drain();
    check_eq("b2b_setup_gap", setup_gap, 1);

    check_eq("apb_q_empty", apb_q.size(), 0);
    check_eq("ahb_q_empty", ahb_q.size(), 0);

    // Asynchronous reset in the middle of an ACCESS phase
    mon_en = 1'b0;
    wait_n = 1000;
    issue(32'h0000_1000, 1'b0, 3'd2, '0);
    @(posedge Hclk); #1;
    @(posedge Hclk); #1;
    check_eq("mid_access_penable", Penable, 1);
    #2;
    Hresetn = 1'b0;
    #1;
    check_eq("rst_mid_psel", Psel, 0);
    check_eq("rst_mid_penable", Penable, 0);
    check_eq("rst_mid_hreadyout", Hreadyout, 1);
    check_eq("rst_mid_hresp", Hresp, 0);
    @(negedge Hclk);
    Hresetn = 1'b1;
    wait_n = 0;
    repeat (2) @(posedge Hclk);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
